// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   - Bus widths for address, data and byte enables.
//   - Watchdog counter width and default abandonment limit.
//   - Arbiter FSM state encoding.
package mem_arb_pkg;

    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int BE_W            = 4;
    localparam int WDOG_W          = 16;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_D_BUSY = 2'd1,
        ST_I_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_wdog_counter.sv
// Watchdog for a granted memory transaction.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - zero the count (takes priority over en)
//   en        - count one busy cycle without mem_ready
//   tc        - terminal count: this enabled cycle is the TIMEOUT-th one,
//               so the transaction is abandoned on the coming edge
module mem_wdog_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    // Firing one count early keeps mem_req high for exactly TIMEOUT cycles.
    assign tc = en & (cnt_q == WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one registered memory port.
// Data has fixed priority; a completing requester is excluded from the
// arbitration on its own completion edge so the other port gets a
// back-to-back grant.
// Ports:
//   clk, rst                          - clock, asynchronous active-low reset
//   if_req/if_addr/if_kill            - fetch request, address, flush
//   if_rdata/if_valid/if_stall        - fetch response and pipeline stall
//   d_req/d_we/d_be/d_addr/d_wdata    - data request
//   d_rdata/d_valid/d_stall           - data response and pipeline stall
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata - registered memory request
//   mem_ready/mem_rdata               - memory completion and read data
//   timeout                           - sticky watchdog error
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              if_stall,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              timeout
);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_valid_q, d_valid_d;
    logic              kill_q, kill_d;
    logic              timeout_q, timeout_d;

    logic busy, done, wdog_tc;
    logic grant_data, grant_fetch;

    assign busy = (state_q != ST_IDLE);
    // A transaction ends either on mem_ready or when the watchdog expires.
    assign done = busy & (mem_ready | wdog_tc);

    mem_wdog_counter #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk (clk),
        .rst (rst),
        .clr (~busy | done),
        .en  (busy & ~mem_ready),
        .tc  (wdog_tc)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        if_valid_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_valid_d   = 1'b0;
        kill_d      = kill_q;
        timeout_d   = timeout_q;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                grant_data  = d_req;
                grant_fetch = ~d_req & if_req & ~if_kill;
            end
            ST_D_BUSY: begin
                if (done) begin
                    d_valid_d   = 1'b1;
                    // Stores and abandoned loads return zero.
                    d_rdata_d   = (mem_ready & ~mem_we_q) ? mem_rdata : '0;
                    grant_fetch = if_req & ~if_kill;
                end
            end
            ST_I_BUSY: begin
                if (if_kill) kill_d = 1'b1;
                if (done) begin
                    kill_d = 1'b0;
                    // A kill seen earlier or on this very edge swallows the pulse.
                    if (~kill_q & ~if_kill) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_ready ? mem_rdata : '0;
                    end
                    grant_data = d_req;
                end
            end
            default: ;
        endcase

        if (done) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            if (~mem_ready) timeout_d = 1'b1;
        end

        if (grant_data) begin
            state_d     = ST_D_BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_be_d    = d_be;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
        end else if (grant_fetch) begin
            state_d     = ST_I_BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_be_d    = '0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_valid_q   <= 1'b0;
            kill_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            d_rdata_q   <= d_rdata_d;
            d_valid_q   <= d_valid_d;
            kill_q      <= kill_d;
            timeout_q   <= timeout_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign timeout   = timeout_q;

    // Stalls are masked during reset so every output reads zero.
    assign d_stall  = rst & d_req & ~d_valid_q;
    assign if_stall = rst & if_req & ~if_valid_q & ~if_kill;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk, rst;
    logic        if_req, if_kill, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_valid, d_valid, if_stall, d_stall, mem_req, mem_we, timeout;
    logic [3:0]  mem_be;

    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .if_stall(if_stall), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL tb_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; if_kill = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    task automatic apply_reset();
        rst = 0;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        d_req = 1; if_req = 1; d_addr = 32'h44; if_addr = 32'h88;
        rst = 1;
        #2 rst = 0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req); end
        checks++; if (d_stall !== 1'b0) begin failures++; $display("FAIL rst_d_stall got=%0h exp=0", d_stall); end
        checks++; if (if_stall !== 1'b0) begin failures++; $display("FAIL rst_if_stall got=%0h exp=0", if_stall); end
        checks++; if ({if_valid, d_valid, timeout, mem_we} !== 4'b0) begin failures++; $display("FAIL rst_flags got=%0h exp=0", {if_valid, d_valid, timeout, mem_we}); end
        checks++; if ({mem_addr, mem_wdata, if_rdata, d_rdata, mem_be} !== 132'b0) begin failures++; $display("FAIL rst_buses got=nonzero exp=0"); end
        step();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_held_mem_req got=%0h exp=0", mem_req); end
        idle_inputs();
        @(negedge clk);
        rst = 1;
        step();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_release_mem_req got=%0h exp=0", mem_req); end
    endtask

    // Simultaneous data load and fetch, memory always ready.
    task automatic test_priority();
        d_req = 1; d_we = 0; d_addr = 32'h100; if_req = 1; if_addr = 32'h40;
        mem_ready = 1; mem_rdata = 32'h1111_1111;
        step();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL prio_first_req got=%0h exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL prio_first_addr got=%0h exp=100", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL prio_first_we got=%0h exp=0", mem_we); end
        mem_rdata = 32'hDDDD_0001;
        step();
        checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL prio_d_valid got=%0h exp=1", d_valid); end
        checks++; if (d_rdata !== 32'hDDDD_0001) begin failures++; $display("FAIL prio_d_rdata got=%0h exp=dddd0001", d_rdata); end
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL prio_b2b_req got=%0h exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h40) begin failures++; $display("FAIL prio_b2b_addr got=%0h exp=40", mem_addr); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL prio_early_if_valid got=%0h exp=0", if_valid); end
        d_req = 0;
        mem_rdata = 32'h1F1F_0002;
        step();
        checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL prio_if_valid got=%0h exp=1", if_valid); end
        checks++; if (if_rdata !== 32'h1F1F_0002) begin failures++; $display("FAIL prio_if_rdata got=%0h exp=1f1f0002", if_rdata); end
        checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL prio_d_valid_len got=%0h exp=0", d_valid); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL prio_idle_req got=%0h exp=0", mem_req); end
        if_req = 0; mem_ready = 0;
        step();
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL prio_if_valid_len got=%0h exp=0", if_valid); end
    endtask

    // Fetch with mem_ready low for three busy cycles.
    task automatic test_fetch_delay();
        int scnt = 0;
        int vcnt = 0;
        int vcyc = -1;
        if_req = 1; if_addr = 32'h40;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc == 1) begin
                checks++; if (mem_addr !== 32'h40 || mem_req !== 1'b1) begin failures++; $display("FAIL fd_mem_req got=%0h/%0h exp=1/40", mem_req, mem_addr); end
            end
            if (if_valid === 1'b1) begin
                vcnt++; vcyc = cyc;
                checks++; if (if_rdata !== 32'h0050_0093) begin failures++; $display("FAIL fd_if_rdata got=%0h exp=00500093", if_rdata); end
                if_req = 0;
            end
            mem_ready = (cyc == 4);
            mem_rdata = (cyc == 4) ? 32'h0050_0093 : 32'hFFFF_FFFF;
            #1;
            if (if_stall === 1'b1) scnt++;
            step();
        end
        mem_ready = 0;
        checks++; if (scnt != 5) begin failures++; $display("FAIL fd_stall_cycles got=%0d exp=5", scnt); end
        checks++; if (vcnt != 1) begin failures++; $display("FAIL fd_valid_count got=%0d exp=1", vcnt); end
        checks++; if (vcyc != 5) begin failures++; $display("FAIL fd_valid_cycle got=%0d exp=5", vcyc); end
    endtask

    task automatic test_kill();
        if_req = 1; if_addr = 32'h60; mem_ready = 0;
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h60) begin failures++; $display("FAIL kill_grant got=%0h/%0h exp=1/60", mem_req, mem_addr); end
        if_kill = 1;
        #1;
        checks++; if (if_stall !== 1'b0) begin failures++; $display("FAIL kill_stall_mask got=%0h exp=0", if_stall); end
        step();
        if_kill = 0; if_req = 0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h60) begin failures++; $display("FAIL kill_inflight got=%0h/%0h exp=1/60", mem_req, mem_addr); end
        mem_ready = 1; mem_rdata = 32'h0000_0BAD;
        step();
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL kill_suppress got=%0h exp=0", if_valid); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL kill_idle got=%0h exp=0", mem_req); end
        mem_ready = 0; if_req = 1; if_addr = 32'h80;
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin failures++; $display("FAIL kill_next_grant got=%0h/%0h exp=1/80", mem_req, mem_addr); end
        mem_ready = 1; mem_rdata = 32'h0000_0013;
        step();
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h13) begin failures++; $display("FAIL kill_next_valid got=%0h/%0h exp=1/13", if_valid, if_rdata); end
        // Kill arriving on the same edge as mem_ready.
        if_addr = 32'hC0; mem_ready = 0;
        step();
        if_kill = 1; mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        step();
        if_kill = 0; if_req = 0; mem_ready = 0;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL kill_same_edge got=%0h exp=0", if_valid); end
        checks++; if (if_rdata !== 32'h13) begin failures++; $display("FAIL kill_rdata_hold got=%0h exp=13", if_rdata); end
        step();
    endtask

    task automatic test_store();
        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h200; d_wdata = 32'hA5A5; mem_ready = 0;
        step();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL st_req_we got=%0h/%0h exp=1/1", mem_req, mem_we); end
        checks++; if (mem_be !== 4'b0011) begin failures++; $display("FAIL st_be got=%0h exp=3", mem_be); end
        checks++; if (mem_addr !== 32'h200 || mem_wdata !== 32'hA5A5) begin failures++; $display("FAIL st_addr_data got=%0h/%0h exp=200/a5a5", mem_addr, mem_wdata); end
        mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        step();
        checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL st_valid got=%0h exp=1", d_valid); end
        checks++; if (d_rdata !== 32'h0) begin failures++; $display("FAIL st_rdata got=%0h exp=0", d_rdata); end
        d_req = 0; d_we = 0; d_be = 0; mem_ready = 0;
        step();
    endtask

    task automatic test_timeout();
        int hi = 0;
        bit got = 0;
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_initial got=%0h exp=0", timeout); end
        d_req = 1; d_we = 0; d_addr = 32'h300; mem_ready = 0; mem_rdata = 32'hFFFF_FFFF;
        for (int cyc = 0; cyc < 20 && !got; cyc++) begin
            step();
            if (mem_req === 1'b1) hi++;
            if (d_valid === 1'b1) begin
                got = 1;
                d_req = 0;
                checks++; if (d_rdata !== 32'h0) begin failures++; $display("FAIL to_rdata got=%0h exp=0", d_rdata); end
            end
        end
        checks++; if (!got) begin failures++; $display("FAIL to_valid got=none exp=pulse"); end
        checks++; if (hi != TO) begin failures++; $display("FAIL to_busy_cycles got=%0d exp=%0d", hi, TO); end
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%0h exp=1", timeout); end
        d_req = 1; d_addr = 32'h304; mem_ready = 1; mem_rdata = 32'h77;
        step();
        step();
        d_req = 0; mem_ready = 0;
        checks++; if (d_valid !== 1'b1 || d_rdata !== 32'h77) begin failures++; $display("FAIL to_recover got=%0h/%0h exp=1/77", d_valid, d_rdata); end
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%0h exp=1", timeout); end
        step();
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 0; d_addr = 32'h400; mem_ready = 0;
        step();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rm_busy got=%0h exp=1", mem_req); end
        #1 rst = 0;
        #1;
        checks++; if ({mem_req, mem_we, d_valid, if_valid, timeout, d_stall, if_stall} !== 7'b0) begin failures++; $display("FAIL rm_flags got=%0h exp=0", {mem_req, mem_we, d_valid, if_valid, timeout, d_stall, if_stall}); end
        checks++; if (mem_addr !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL rm_buses got=%0h/%0h exp=0/0", mem_addr, d_rdata); end
        idle_inputs();
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1;
            step();
            checks++; if (d_valid !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL rm_after got=%0h/%0h exp=0/0", d_valid, mem_req); end
        end
        mem_ready = 0;
    endtask

    // Random traffic against a transaction-level model: memory owner,
    // expected request fields, completions one cycle after ready/expiry.
    task automatic test_random();
        int own = 0;     // 0 none, 1 data, 2 fetch
        int excl;
        int waited = 0;
        logic [31:0] ea = 0, ewd = 0, edrd = 0, eird = 0;
        logic ewe = 0, edv = 0, eiv = 0, eto = 0, fin, expired;
        logic [3:0] ebe = 0;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++; if (d_valid !== edv) begin failures++; $display("FAIL rnd_d_valid cyc=%0d got=%0h exp=%0h", cyc, d_valid, edv); end
            checks++; if (if_valid !== eiv) begin failures++; $display("FAIL rnd_if_valid cyc=%0d got=%0h exp=%0h", cyc, if_valid, eiv); end
            checks++; if (d_rdata !== edrd) begin failures++; $display("FAIL rnd_d_rdata cyc=%0d got=%0h exp=%0h", cyc, d_rdata, edrd); end
            checks++; if (if_rdata !== eird) begin failures++; $display("FAIL rnd_if_rdata cyc=%0d got=%0h exp=%0h", cyc, if_rdata, eird); end
            checks++; if (timeout !== eto) begin failures++; $display("FAIL rnd_timeout cyc=%0d got=%0h exp=%0h", cyc, timeout, eto); end
            checks++; if (mem_req !== (own != 0)) begin failures++; $display("FAIL rnd_mem_req cyc=%0d got=%0h exp=%0h", cyc, mem_req, own != 0); end
            if (own != 0) begin
                checks++; if (mem_addr !== ea || mem_we !== ewe || mem_be !== ebe) begin failures++; $display("FAIL rnd_mem_cmd cyc=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", cyc, mem_addr, mem_we, mem_be, ea, ewe, ebe); end
                if (own == 1) begin
                    checks++; if (mem_wdata !== ewd) begin failures++; $display("FAIL rnd_mem_wdata cyc=%0d got=%0h exp=%0h", cyc, mem_wdata, ewd); end
                end
            end
            // Requesters: hold until completion, may re-request in the valid cycle.
            if (edv || (!d_req && $urandom_range(0, 2) == 0)) begin
                d_req = edv ? 1'($urandom_range(0, 1)) : 1'b1;
                d_we = 1'($urandom_range(0, 1));
                d_be = 4'($urandom());
                d_addr = 32'h1000_0000 | ($urandom() & 32'h0000_FFFC);
                d_wdata = $urandom();
            end
            if (eiv || (!if_req && $urandom_range(0, 2) == 0)) begin
                if_req = eiv ? 1'($urandom_range(0, 1)) : 1'b1;
                if_addr = $urandom() & 32'h0000_FFFC;
            end
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom();
            #1;
            checks++; if (d_stall !== (d_req & ~edv)) begin failures++; $display("FAIL rnd_d_stall cyc=%0d got=%0h exp=%0h", cyc, d_stall, d_req & ~edv); end
            checks++; if (if_stall !== (if_req & ~eiv)) begin failures++; $display("FAIL rnd_if_stall cyc=%0d got=%0h exp=%0h", cyc, if_stall, if_req & ~eiv); end
            // Predict the outcome of the coming edge.
            edv = 0; eiv = 0; fin = 0; expired = 0; excl = 0;
            if (own != 0) begin
                if (mem_ready) fin = 1;
                else if (waited + 1 == TO) begin fin = 1; expired = 1; end
                else waited++;
            end
            if (fin) begin
                excl = own;
                if (own == 1) begin edv = 1; edrd = (expired || ewe) ? 32'h0 : mem_rdata; end
                else begin eiv = 1; eird = expired ? 32'h0 : mem_rdata; end
                if (expired) eto = 1;
                own = 0;
            end
            if (own == 0) begin
                if (d_req && excl != 1) begin
                    own = 1; ea = d_addr; ewe = d_we; ebe = d_be; ewd = d_wdata; waited = 0;
                end else if (if_req && excl != 2) begin
                    own = 2; ea = if_addr; ewe = 0; ebe = 0; waited = 0;
                end
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_priority();
        test_fetch_delay();
        test_kill();
        test_store();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
